// File: rtl/mux_4to1_pkg.sv
// Shared constants and select-code type for the 4:1 datapath multiplexer.
package mux_4to1_pkg;

    localparam int unsigned MUX_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        SEL_I0 = 2'b00,
        SEL_I1 = 2'b01,
        SEL_I2 = 2'b10,
        SEL_I3 = 2'b11
    } sel_t;

endpackage

// File: rtl/mux_4to1_if.sv
// Bus bundle for mux_4to1: data inputs, select, load enable and outputs.
// Optional parity outputs exist only when MUX4TO1_PARITY_EN is defined.
interface mux_4to1_if
    import mux_4to1_pkg::*;
#(
    parameter int unsigned WIDTH = MUX_WIDTH_DEF
);

    logic             en;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic [WIDTH-1:0] I2;
    logic [WIDTH-1:0] I3;
    logic [1:0]       Sel;
    logic [WIDTH-1:0] Data_out;
    logic [WIDTH-1:0] Data_q;
`ifdef MUX4TO1_PARITY_EN
    logic             par_out;
    logic             par_q;
`endif

    modport master (
        output en, I0, I1, I2, I3, Sel,
`ifdef MUX4TO1_PARITY_EN
        input  par_out, par_q,
`endif
        input  Data_out, Data_q
    );

    modport slave (
        input  en, I0, I1, I2, I3, Sel,
`ifdef MUX4TO1_PARITY_EN
        output par_out, par_q,
`endif
        output Data_out, Data_q
    );

endinterface

// File: rtl/mux_4to1_core.sv
// Pure combinational 4:1 select; any unresolved select code falls back to I0.
module mux_4to1_core
    import mux_4to1_pkg::*;
#(
    parameter int unsigned WIDTH = MUX_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [1:0]       Sel,
    output logic [WIDTH-1:0] Data_out
);

    always_comb begin
        unique case (sel_t'(Sel))
            SEL_I1:  Data_out = I1;
            SEL_I2:  Data_out = I2;
            SEL_I3:  Data_out = I3;
            default: Data_out = I0;
        endcase
    end

endmodule

// File: rtl/mux_4to1.sv
// 4:1 multiplexer with a registered, load-enabled copy of the selection.
// Define MUX4TO1_PARITY_EN to add even-parity outputs par_out / par_q.
module mux_4to1
    import mux_4to1_pkg::*;
#(
    parameter int unsigned WIDTH = MUX_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mux_4to1_if.slave     bus
);

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    mux_4to1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .I0       (bus.I0),
        .I1       (bus.I1),
        .I2       (bus.I2),
        .I3       (bus.I3),
        .Sel      (bus.Sel),
        .Data_out (data_out)
    );

    always_comb begin
        data_d = data_q;
        if (bus.en) data_d = data_out;
    end

    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign bus.Data_out = data_out;
    assign bus.Data_q   = data_q;

`ifdef MUX4TO1_PARITY_EN
    logic par_out;
    logic par_d;
    logic par_q;

    always_comb begin
        par_out = ^data_out;
        par_d   = par_q;
        if (bus.en) par_d = par_out;
    end

    always_ff @(posedge clk) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end

    assign bus.par_out = par_out;
    assign bus.par_q   = par_q;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1 (WIDTH=4): directed table, corner
// sequences, randomized cycles against an array-indexed model, exhaustive sweep.
module tb_mux_4to1;
    import mux_4to1_pkg::*;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux_4to1_if #(.WIDTH(W)) bus ();

    mux_4to1 #(.WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] i0, i1, i2, i3;
        logic [W-1:0] exp_out;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic [W-1:0] a, b, c, d,
                         input logic e, input logic r);
        bus.Sel = s;
        bus.I0  = a;
        bus.I1  = b;
        bus.I2  = c;
        bus.I3  = d;
        bus.en  = e;
        rst     = r;
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] ins[4];
    logic [W-1:0] exp_q;
    logic         exp_pq;
    logic         r_rst, r_en;
    logic [1:0]   r_sel;

    initial begin
        drive(2'd0, '0, '0, '0, '0, 1'b0, 1'b1);

        // reset state
        edge_then_settle();
        edge_then_settle();
        check("reset_q", 32'(bus.Data_q), 32'h0);
`ifdef MUX4TO1_PARITY_EN
        check("reset_par_q", 32'(bus.par_q), 32'h0);
`endif
        rst = 1'b0;

        // directed select table
        vecs[0] = '{2'd0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        vecs[1] = '{2'd1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h2};
        vecs[2] = '{2'd2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4};
        vecs[3] = '{2'd3, 4'h1, 4'h2, 4'h4, 4'h8, 4'h8};
        vecs[4] = '{2'd0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF};
        vecs[5] = '{2'd3, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
        vecs[6] = '{2'd2, 4'h5, 4'hA, 4'h6, 4'h9, 4'h6};
        vecs[7] = '{2'd1, 4'h5, 4'hA, 4'h6, 4'h9, 4'hA};
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].sel, vecs[i].i0, vecs[i].i1, vecs[i].i2, vecs[i].i3, 1'b0, 1'b0);
            #1;
            check($sformatf("table_%0d", i), 32'(bus.Data_out), 32'(vecs[i].exp_out));
        end

        // held register must not move while en=0
        edge_then_settle();
        check("hold_after_reset", 32'(bus.Data_q), 32'h0);

        // preload F, then rst with en: reset wins, Data_out unaffected
        @(negedge clk);
        drive(2'd0, 4'hF, 4'h1, 4'h2, 4'h3, 1'b1, 1'b0);
        edge_then_settle();
        check("preload_q", 32'(bus.Data_q), 32'hF);
        @(negedge clk);
        rst = 1'b1;
        edge_then_settle();
        check("rst_over_en_q", 32'(bus.Data_q), 32'h0);
        check("rst_out_unaffected", 32'(bus.Data_out), 32'hF);
        @(negedge clk);
        rst = 1'b0;
        bus.en = 1'b0;

        // enable / latency / hold
        @(negedge clk);
        drive(2'd2, 4'h0, 4'h0, 4'hA, 4'h0, 1'b1, 1'b0);
        #1;
        check("latency_before_edge", 32'(bus.Data_q), 32'h0);
        edge_then_settle();
        check("latency_one_edge", 32'(bus.Data_q), 32'hA);
        @(negedge clk);
        bus.en = 1'b0;
        bus.I2 = 4'h5;
        #1;
        check("hold_out_follows", 32'(bus.Data_out), 32'h5);
        edge_then_settle();
        check("hold_q", 32'(bus.Data_q), 32'hA);

        // unresolved select falls back to I0
        @(negedge clk);
        drive(2'bxx, 4'h3, 4'hC, 4'hC, 4'hC, 1'b0, 1'b0);
        #1;
        check("sel_x", 32'(bus.Data_out), 32'h3);

`ifdef MUX4TO1_PARITY_EN
        @(negedge clk);
        drive(2'd1, 4'h0, 4'b0111, 4'h0, 4'h0, 1'b1, 1'b0);
        #1;
        check("par_out_odd", 32'(bus.par_out), 32'h1);
        edge_then_settle();
        check("par_q_odd", 32'(bus.par_q), 32'h1);
        @(negedge clk);
        bus.en = 1'b0;
        bus.I1 = 4'b0011;
        #1;
        check("par_out_even", 32'(bus.par_out), 32'h0);
        check("par_q_hold", 32'(bus.par_q), 32'h1);
`endif

        // randomized cycles against a behavioural model
        @(negedge clk);
        drive(2'd0, '0, '0, '0, '0, 1'b0, 1'b1);
        edge_then_settle();
        exp_q  = '0;
        exp_pq = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) ins[k] = W'($urandom);
            r_sel = 2'($urandom);
            r_en  = ($urandom_range(0, 2) != 0);
            r_rst = ($urandom_range(0, 15) == 0);
            drive(r_sel, ins[0], ins[1], ins[2], ins[3], r_en, r_rst);
            #1;
            check("rand_out", 32'(bus.Data_out), 32'(ins[r_sel]));
`ifdef MUX4TO1_PARITY_EN
            check("rand_par_out", 32'(bus.par_out), 32'($countones(ins[r_sel]) % 2));
`endif
            if (r_rst) begin
                exp_q  = '0;
                exp_pq = 1'b0;
            end else if (r_en) begin
                exp_q  = ins[r_sel];
                exp_pq = 1'($countones(ins[r_sel]) % 2);
            end
            edge_then_settle();
            check("rand_q", 32'(bus.Data_q), 32'(exp_q));
`ifdef MUX4TO1_PARITY_EN
            check("rand_par_q", 32'(bus.par_q), 32'(exp_pq));
`endif
        end

        // exhaustive combinational sweep
        @(negedge clk);
        bus.en = 1'b0;
        rst    = 1'b0;
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    for (int c = 0; c < 16; c++)
                        for (int d = 0; d < 16; d++) begin
                            ins[0] = W'(a);
                            ins[1] = W'(b);
                            ins[2] = W'(c);
                            ins[3] = W'(d);
                            drive(2'(s), ins[0], ins[1], ins[2], ins[3], 1'b0, 1'b0);
                            #1;
                            check("sweep", 32'(bus.Data_out), 32'(ins[s]));
                        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_4to1.md
Name: mux_4to1

Overview:
- Parameterised 4-input, WIDTH-bit multiplexer used as a generic datapath selector.
- Combinational output: Data_out follows Sel and the inputs with zero cycle latency.
- Registered copy Data_q, with load enable and synchronous active-high reset, for timing-critical consumers.
- Single clock domain.

Parameters:
- WIDTH, default 4, bit width of each data input and of both data outputs (legal range ≥1).

Ports:
- clk  input  1  sole clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  load enable for Data_q.
- I0  input  WIDTH  data input, selected when Sel=2'b00.
- I1  input  WIDTH  data input, selected when Sel=2'b01.
- I2  input  WIDTH  data input, selected when Sel=2'b10.
- I3  input  WIDTH  data input, selected when Sel=2'b11.
- Sel  input  2  binary select code.
- Data_out  output  WIDTH  combinational selected data.
- Data_q  output  WIDTH  registered selected data.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Data_out, combinational, no clock involvement:
  - Sel=0 → I0; Sel=1 → I1; Sel=2 → I2; Sel=3 → I3.
  - Must settle within one simulation time step of any input change.
- Sel containing X/Z: Data_out = I0 (default branch). No X propagation from Sel is required.
- Data_out ignores rst and en entirely.
- Data_q, on rising clk edge:
  - rst=1 → Data_q <= 0 (all WIDTH bits).
  - else en=1 → Data_q <= current Data_out value.
  - else hold.
- Data_q latency: exactly one cycle after a sample edge where en=1.
- rst has priority over en when both are asserted.
- Reset mid-operation: Data_q clears on that edge; Data_out is unaffected.
- Width rule: pure bit selection, no arithmetic. All 4×2^(4·WIDTH) input combinations must produce exact equality with the selected input; every bit is routed independently.
- No state machine; the only state is Data_q (plus the parity flop below when enabled).

Optional Feature:
- Macro: MUX4TO1_PARITY_EN.
- Defined:
  - Adds output par_out (1 bit, combinational) = XOR-reduction of Data_out, i.e. even-parity bit.
  - Adds output par_q (1 bit, registered) with the same rst/en rules as Data_q; reset value 0.
- Undefined: neither port exists; the rest of the behaviour is identical.

Decomposition:
- Package mux_4to1_pkg holds:
  - default width constant MUX_WIDTH_DEF = 4;
  - select encodings SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10, SEL_I3=2'b11 as a 2-bit typedef sel_t.
- One sub-module is natural: mux_4to1_core, a pure combinational select (WIDTH parameter, I0–I3, Sel → Data_out).
- Top level wraps the core with the Data_q register and the optional parity logic.

Test Plan:
- Exhaustive combinational sweep, WIDTH=4: all Sel 0–3 × I0..I3 each 0–15, checked 1 time unit after each change.
  - Data_out must equal the selected input for every vector; error count 0.
- Directed select: I0=4'h1, I1=4'h2, I2=4'h4, I3=4'h8; Sel stepped 0,1,2,3 → Data_out 1,2,4,8.
- Reset: Data_q preloaded to 4'hF, rst=1 with en=1 for one edge.
  - Data_q=0 after the edge; Data_out still equals the selected input.
- Enable/latency: Sel=2, I2=4'hA, en=1.
  - Data_q=4'hA one edge later.
  - Then en=0 and I2=4'h5: Data_q holds 4'hA while Data_out=4'h5.
- Sel X: Sel=2'bxx, I0=4'h3, others 4'hC → Data_out=4'h3.
- With MUX4TO1_PARITY_EN defined: Sel=1, I1=4'b0111 → par_out=1; after an en edge, par_q=1.
  - Then I1=4'b0011 → par_out=0.
